// File: rtl/score_digit_renderer.sv
// score_digit_renderer
//   Multi-digit HUD number renderer. A sequential double-dabble converter turns
//   a binary value into BCD and commits it atomically. An independent pixel
//   pipeline maps (digit slot, x, y) requests onto glyph-ROM addresses and
//   gates the returned ROM bit with a registered blank flag.
//   Optional feature macro: LEADING_ZERO_BLANK_EN. When it is defined, slots
//   above the most significant nonzero digit are blanked. Slot 0 is never
//   blanked, and overflow suppresses the blanking.
module score_digit_renderer #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 14,
    parameter int GLYPH_W     = 30,
    parameter int GLYPH_H     = 30,
    parameter int ROM_AW      = 14,
    parameter int ROM_LATENCY = 1,
    localparam int SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int X_W        = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1,
    localparam int Y_W        = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [VALUE_W-1:0]      value_in,
    input  logic                    value_load,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    overflow,
    input  logic                    pix_valid_in,
    input  logic [SEL_W-1:0]        digit_sel,
    input  logic [X_W-1:0]          pix_x,
    input  logic [Y_W-1:0]          pix_y,
    output logic [ROM_AW-1:0]       rom_addr,
    input  logic                    rom_q,
    output logic                    pix_valid_out,
    output logic                    pix_on
);

    // One spare nibble above the displayed digits catches values that need an extra digit.
    localparam int SCR_W = 4 * NUM_DIGITS + 4;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_pend_vld;
    logic [VALUE_W-1:0]      r_pend_val;
    logic [SCR_W-1:0]        r_scr;
    logic [VALUE_W-1:0]      r_bin;
    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic                    r_ovf;

    logic                    w_start;
    logic [VALUE_W-1:0]      w_load_val;
    logic [SCR_W-1:0]        w_scr_adj;
    logic                    w_scr_ovf;

    logic [ROM_AW-1:0]       r_rom_addr;
    logic                    r_vld_p0;
    logic                    r_blank_p0;
    logic                    r_vld_pd   [ROM_LATENCY];
    logic                    r_blank_pd [ROM_LATENCY];

    logic [3:0]              w_digit;
    logic                    w_range_bad;
    logic                    w_lzb;
    logic [ROM_AW-1:0]       w_addr;

    // Adds 3 to every nibble >= 5 so that the following left shift carries correctly into the next decimal place.
    function automatic logic [SCR_W-1:0] dabble_adjust(input logic [SCR_W-1:0] s);
        logic [SCR_W-1:0] r;
        r = s;
        for (int i = 0; i < NUM_DIGITS + 1; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Selects the nibble for a slot. A slot that does not exist reads as 0.
    function automatic logic [3:0] digit_of(input logic [4*NUM_DIGITS-1:0] bcd,
                                            input logic [SEL_W-1:0]        sel);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(sel) == i) begin
                d = bcd[4*i +: 4];
            end
        end
        return d;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A slot is a leading zero when it lies above the highest nonzero digit. Slot 0 is always kept.
    function automatic logic lead_zero_blank(input logic [4*NUM_DIGITS-1:0] bcd,
                                             input logic                    ovf,
                                             input logic [SEL_W-1:0]        sel);
        int msd;
        msd = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end
        return !ovf && (int'(sel) > msd);
    endfunction

    assign w_lzb = lead_zero_blank(r_bcd, r_ovf, digit_sel);
`else
    assign w_lzb = 1'b0;
`endif

    // A load that arrives in the commit cycle goes straight into the next conversion, and it overrides the queued value.
    assign w_load_val = value_load ? value_in : r_pend_val;
    assign w_start    = ((r_state == S_IDLE) || (r_state == S_COMMIT)) && (value_load || r_pend_vld);
    assign w_scr_adj  = dabble_adjust(r_scr);
    assign w_scr_ovf  = |r_scr[SCR_W-1 -: 4];

    // Conversion control: sequencing, the pending flag and the committed result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pend_vld <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state    <= S_SHIFT;
                        r_cnt      <= '0;
                        r_pend_vld <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (value_load) begin
                        r_pend_vld <= 1'b1;
                    end
                    if (r_cnt == CNT_W'(VALUE_W - 1)) begin
                        r_state <= S_COMMIT;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_COMMIT: begin
                    if (w_scr_ovf) begin
                        r_bcd <= {NUM_DIGITS{4'h9}};
                        r_ovf <= 1'b1;
                    end else begin
                        r_bcd <= r_scr[4*NUM_DIGITS-1:0];
                        r_ovf <= 1'b0;
                    end
                    r_pend_vld <= 1'b0;
                    if (w_start) begin
                        r_state <= S_SHIFT;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Double-dabble datapath: the BCD scratch and the binary shifter, loaded when a conversion starts.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_scr <= '0;
            r_bin <= w_load_val;
        end else if (r_state == S_SHIFT) begin
            r_scr <= {w_scr_adj[SCR_W-2:0], r_bin[VALUE_W-1]};
            r_bin <= r_bin << 1;
        end
    end

    // Holds the most recent value_load seen while a conversion is running.
    always_ff @(posedge clk) begin
        if (value_load && (r_state == S_SHIFT)) begin
            r_pend_val <= value_in;
        end
    end

    // Render front end: digit lookup, range checks and the glyph address, all at full ROM_AW width.
    always_comb begin
        w_digit     = digit_of(r_bcd, digit_sel);
        w_range_bad = (int'(digit_sel) >= NUM_DIGITS) || (int'(pix_x) >= GLYPH_W) ||
                      (int'(pix_y) >= GLYPH_H);
        w_addr      = ROM_AW'(w_digit) * ROM_AW'(GLYPH_W * GLYPH_H) +
                      ROM_AW'(pix_y) * ROM_AW'(GLYPH_W) + ROM_AW'(pix_x);
    end

    // S0 registers the address and blank flag, then valid and blank follow the ROM for ROM_LATENCY cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rom_addr <= '0;
            r_vld_p0   <= 1'b0;
            r_blank_p0 <= 1'b0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                r_vld_pd[i]   <= 1'b0;
                r_blank_pd[i] <= 1'b0;
            end
        end else begin
            r_vld_p0      <= pix_valid_in;
            r_blank_p0    <= w_range_bad || w_lzb;
            r_rom_addr    <= w_range_bad ? '0 : w_addr;
            r_vld_pd[0]   <= r_vld_p0;
            r_blank_pd[0] <= r_blank_p0;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_vld_pd[i]   <= r_vld_pd[i-1];
                r_blank_pd[i] <= r_blank_pd[i-1];
            end
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign bcd_out       = r_bcd;
    assign overflow      = r_ovf;
    assign rom_addr      = r_rom_addr;
    assign pix_valid_out = r_vld_pd[ROM_LATENCY-1];
    assign pix_on        = rom_q & ~r_blank_pd[ROM_LATENCY-1] & r_vld_pd[ROM_LATENCY-1];

endmodule

// File: tb/tb_score_digit_renderer.sv
// tb_score_digit_renderer
//   Scoreboard bench for score_digit_renderer. A behavioural model predicts
//   conversion commits and pixel responses from decimal arithmetic. A
//   negedge monitor pops those predictions and compares them with the DUT.
//   The glyph ROM is modelled here as a pseudo-random bitmap with ROM_LATENCY.
module tb_score_digit_renderer;

    localparam int ND   = 4;
    localparam int VW   = 14;
    localparam int GW   = 30;
    localparam int GH   = 30;
    localparam int AW   = 14;
    localparam int LAT  = 1;
    localparam int SW   = (ND > 1) ? $clog2(ND) : 1;
    localparam int XW   = (GW > 1) ? $clog2(GW) : 1;
    localparam int YW   = (GH > 1) ? $clog2(GH) : 1;
    localparam int MAXV = 10**ND - 1;

    typedef struct { int t; int addr; logic on; } pix_exp_t;
    typedef struct { int t; int bcd; logic ovf; } conv_exp_t;
    typedef struct { int sel; int x; int y; } req_t;

    logic              clk;
    logic              resetn;
    logic [VW-1:0]     value_in;
    logic              value_load;
    logic              busy;
    logic [4*ND-1:0]   bcd_out;
    logic              overflow;
    logic              pix_valid_in;
    logic [SW-1:0]     digit_sel;
    logic [XW-1:0]     pix_x;
    logic [YW-1:0]     pix_y;
    logic [AW-1:0]     rom_addr;
    logic              rom_q;
    logic              pix_valid_out;
    logic              pix_on;

    logic [AW-1:0]     rom_pipe [LAT];
    logic              rom_force;
    logic              stream_en;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    pix_exp_t  pix_q[$];
    conv_exp_t conv_q[$];
    req_t      dir_q[$];

    logic m_active;
    logic m_pend;
    int   m_pend_val;
    int   m_cur;
    int   m_comm;
    int   m_commit_t;
    int   mon_bcd;
    logic mon_ovf;

    score_digit_renderer #(
        .NUM_DIGITS (ND),
        .VALUE_W    (VW),
        .GLYPH_W    (GW),
        .GLYPH_H    (GH),
        .ROM_AW     (AW),
        .ROM_LATENCY(LAT)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .value_in     (value_in),
        .value_load   (value_load),
        .busy         (busy),
        .bcd_out      (bcd_out),
        .overflow     (overflow),
        .pix_valid_in (pix_valid_in),
        .digit_sel    (digit_sel),
        .pix_x        (pix_x),
        .pix_y        (pix_y),
        .rom_addr     (rom_addr),
        .rom_q        (rom_q),
        .pix_valid_out(pix_valid_out),
        .pix_on       (pix_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic glyph(input int a);
        int h;
        h = a * 37 + (a >> 2) + 11;
        return h[4] ^ h[9];
    endfunction

    // Glyph ROM with a fixed read latency.
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr;
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_q = rom_force ? 1'b1 : glyph(int'(rom_pipe[LAT-1]));

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h) t=%0t", name, act, act, want, want, $time);
        end
    endtask

    function automatic int bcd_of(input int v);
        int r;
        int p;
        r = 0;
        if (v > MAXV) begin
            for (int k = 0; k < ND; k++) r = (r << 4) | 9;
            return r;
        end
        p = v;
        for (int k = 0; k < ND; k++) begin
            r = r | ((p % 10) << (4 * k));
            p = p / 10;
        end
        return r;
    endfunction

    task automatic exp_pixel(input int v, input int sel, input int x, input int y,
                             output int addr, output logic blank);
        logic ovf;
        logic bad;
        int   dig;
        int   p;
        int   msd;
        ovf = (v > MAXV);
        bad = (sel >= ND) || (x >= GW) || (y >= GH);
        p = 1;
        for (int k = 0; k < sel; k++) p = p * 10;
        dig = ovf ? 9 : ((v / p) % 10);
        addr = bad ? 0 : (dig * GW * GH + y * GW + x);
        blank = bad;
        msd = 0;
        for (int k = 0, q = 1; k < ND; k++, q = q * 10) begin
            if (((v / q) % 10) != 0) msd = k;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (!ovf && sel > msd) blank = 1'b1;
`endif
    endtask

    task automatic model_clear();
        m_active = 1'b0;
        m_pend   = 1'b0;
        m_comm   = 0;
        mon_bcd  = 0;
        mon_ovf  = 1'b0;
        pix_q.delete();
        conv_q.delete();
    endtask

    // Reference model: predicts commit times, committed values and pixel results at each rising edge.
    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            cyc++;
            if (!resetn) begin
                model_clear();
            end else begin
                if (pix_valid_in) begin
                    pix_exp_t e;
                    int       a;
                    logic     bl;
                    exp_pixel(m_comm, int'(digit_sel), int'(pix_x), int'(pix_y), a, bl);
                    e.t    = cyc;
                    e.addr = a;
                    e.on   = (rom_force ? 1'b1 : glyph(a)) & ~bl;
                    pix_q.push_back(e);
                end
                if (m_active && cyc == m_commit_t) begin
                    conv_exp_t c;
                    c.t   = cyc;
                    c.bcd = bcd_of(m_cur);
                    c.ovf = (m_cur > MAXV);
                    conv_q.push_back(c);
                    m_comm = m_cur;
                    if (value_load) begin
                        m_cur = int'(value_in);
                        m_commit_t = cyc + VW + 1;
                    end else if (m_pend) begin
                        m_cur = m_pend_val;
                        m_commit_t = cyc + VW + 1;
                    end else begin
                        m_active = 1'b0;
                    end
                    m_pend = 1'b0;
                end else if (m_active) begin
                    if (value_load) begin
                        m_pend     = 1'b1;
                        m_pend_val = int'(value_in);
                    end
                end else if (value_load) begin
                    m_active   = 1'b1;
                    m_cur      = int'(value_in);
                    m_commit_t = cyc + VW + 1;
                end
            end
        end
    end

    // Monitor: consumes predictions on the falling edge and compares them with the DUT outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn) begin
                while (conv_q.size() > 0 && conv_q[0].t <= cyc) begin
                    mon_bcd = conv_q[0].bcd;
                    mon_ovf = conv_q[0].ovf;
                    void'(conv_q.pop_front());
                end
                chk("bcd_out", int'(bcd_out), mon_bcd);
                chk("overflow", int'(overflow), int'(mon_ovf));
                chk("busy", int'(busy), int'(m_active));
                if (pix_valid_out) begin
                    if (pix_q.size() == 0) begin
                        chk("pix_unexpected_valid", int'(pix_valid_out), 0);
                    end else begin
                        pix_exp_t e;
                        e = pix_q.pop_front();
                        chk("pix_latency", cyc, e.t + LAT);
                        chk("rom_addr", int'(rom_pipe[LAT-1]), e.addr);
                        chk("pix_on", int'(pix_on), int'(e.on));
                    end
                end else begin
                    chk("pix_on_idle", int'(pix_on), 0);
                    if (pix_q.size() > 0 && pix_q[0].t + LAT <= cyc) begin
                        chk("pix_missing_valid", int'(pix_valid_out), 1);
                        void'(pix_q.pop_front());
                    end
                end
            end
        end
    end

    // Pixel request driver: directed requests take priority over the random stream.
    initial begin
        pix_valid_in = 1'b0;
        digit_sel    = '0;
        pix_x        = '0;
        pix_y        = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dir_q.size() > 0) begin
                req_t r;
                r = dir_q.pop_front();
                pix_valid_in = 1'b1;
                digit_sel    = SW'(r.sel);
                pix_x        = XW'(r.x);
                pix_y        = YW'(r.y);
            end else if (stream_en) begin
                pix_valid_in = ($urandom_range(0, 3) != 0);
                digit_sel    = SW'($urandom_range(0, ND - 1));
                pix_x        = XW'($urandom_range(0, (1 << XW) - 1));
                pix_y        = YW'($urandom_range(0, (1 << YW) - 1));
            end else begin
                pix_valid_in = 1'b0;
            end
        end
    end

    task automatic do_load(input int v);
        @(posedge clk);
        #1;
        value_in   = VW'(v);
        value_load = 1'b1;
        @(posedge clk);
        #1;
        value_load = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int n);
        n = 0;
        while (busy && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic push_req(input int sel, input int x, input int y);
        req_t r;
        r.sel = sel;
        r.x   = x;
        r.y   = y;
        dir_q.push_back(r);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "simulation timeout");
    end

    initial begin
        int n;
        resetn     = 1'b0;
        value_load = 1'b0;
        value_in   = '0;
        stream_en  = 1'b0;
        rom_force  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_bcd", int'(bcd_out), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_pix_valid_out", int'(pix_valid_out), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_pix_on", int'(pix_on), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Plain conversion and its busy window.
        do_load(1234);
        wait_idle(100, n);
        chk("t1_busy_cycles", n, 15);
        chk("t1_bcd", int'(bcd_out), 'h1234);
        chk("t1_overflow", int'(overflow), 0);

        // Overflow saturates the display, and the next in-range value clears it.
        do_load(12000);
        wait_idle(100, n);
        chk("t2_bcd_sat", int'(bcd_out), 'h9999);
        chk("t2_overflow", int'(overflow), 1);
        do_load(7);
        wait_idle(100, n);
        chk("t2_bcd_7", int'(bcd_out), 'h0007);
        chk("t2_overflow_clr", int'(overflow), 0);

        // Loads while busy: only the last queued value follows the current one.
        do_load(5);
        do_load(6);
        repeat (3) @(posedge clk);
        do_load(9);
        wait_idle(100, n);
        chk("t3_idle_bound", int'(busy), 0);
        chk("t3_bcd", int'(bcd_out), 'h0009);

        // Address formation and latency for a single request.
        do_load(42);
        wait_idle(100, n);
        chk("t4_bcd", int'(bcd_out), 'h0042);
        @(negedge clk);
        push_req(1, 3, 2);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("t4_rom_addr", int'(rom_addr), 3663);
        n = 0;
        while (!pix_valid_out && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t4_pix_lat", n, LAT);
        chk("t4_pix_on", int'(pix_on), int'(rom_q));

        // Blanking with a lit ROM: leading-zero slots and out-of-range coordinates.
        repeat (4) @(posedge clk);
        @(negedge clk);
        rom_force = 1'b1;
        for (int s = 0; s < ND; s++) push_req(s, 1, 1);
        push_req(0, 31, 0);
        push_req(1, 0, 30);
        repeat (12) @(posedge clk);
        do_load(0);
        wait_idle(100, n);
        @(negedge clk);
        push_req(0, 5, 5);
        push_req(1, 5, 5);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rom_force = 1'b0;

        // Reset in the middle of a conversion while pixels are streaming.
        stream_en = 1'b1;
        do_load(int'($urandom_range(0, 16383)));
        repeat (5) @(posedge clk);
        #3;
        resetn = 1'b0;
        model_clear();
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_pix_valid_out", int'(pix_valid_out), 0);
        chk("t6_bcd", int'(bcd_out), 0);
        chk("t6_overflow", int'(overflow), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        // Random loads, some out of range and some back to back, with the stream running.
        for (int i = 0; i < 40; i++) begin
            int v;
            v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MAXV + 1, (1 << VW) - 1))
                                            : int'($urandom_range(0, MAXV));
            do_load(v);
            repeat ($urandom_range(0, 25)) @(posedge clk);
        end
        wait_idle(200, n);
        chk("final_idle", int'(busy), 0);
        stream_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("drain_pix_q", pix_q.size(), 0);
        chk("drain_conv_q", conv_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
